// File: rtl/alu_rs_pkg.sv
// Shared widths, op-class codes and record types for the ALU reservation station.
// Also holds the broadcast-snoop helper used at issue time and during wakeup.
package alu_rs_pkg;

    localparam int OP_WIDTH        = 7;
    localparam int VAL_WIDTH       = 32;
    localparam int ROB_ID_WIDTH    = 3;
    localparam int ADDR_WIDTH      = 32;
    localparam int TAG_WIDTH       = ROB_ID_WIDTH + 1;
    localparam int RS_SIZE_DEFAULT = 8;

    typedef logic [OP_WIDTH-1:0]   op_t;
    typedef logic [VAL_WIDTH-1:0]  val_t;
    typedef logic [TAG_WIDTH-1:0]  tag_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    typedef enum logic [2:0] {
        OP_B_TYPE     = 3'd0,
        OP_I_TYPE     = 3'd1,
        OP_R_TYPE     = 3'd2,
        OP_AUIPC_TYPE = 3'd3,
        OP_LUI_TYPE   = 3'd4,
        OP_JAL_TYPE   = 3'd5,
        OP_JALR_TYPE  = 3'd6
    } op_class_e;

    // busy means the value is still owed by the producer named in tag.
    typedef struct packed {
        logic busy;
        tag_t tag;
        val_t val;
    } operand_t;

    typedef struct packed {
        logic ready;
        tag_t tag;
        val_t val;
    } bcast_t;

    typedef struct packed {
        logic     busy;
        op_t      op;
        operand_t j;
        operand_t k;
        tag_t     dest;
        addr_t    pc;
    } rs_entry_t;

    function automatic op_t make_op(op_class_e cls, logic [2:0] funct3, logic variant);
        return {variant, funct3, cls};
    endfunction

    // ALU is checked first so it wins if both units broadcast the same tag.
    function automatic operand_t snoop(operand_t opnd, bcast_t alu, bcast_t lsb);
        operand_t res;
        res = opnd;
        if (opnd.busy) begin
            if (alu.ready && alu.tag == opnd.tag) begin
                res.busy = 1'b0;
                res.val  = alu.val;
            end else if (lsb.ready && lsb.tag == opnd.tag) begin
                res.busy = 1'b0;
                res.val  = lsb.val;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/alu_rs_if.sv
// Issue, broadcast and dispatch signals between the issue stage, the RS and the ALU.
// master = environment (issue stage, result buses, ALU sink); slave = reservation station.
interface alu_rs_if;
    import alu_rs_pkg::*;

    logic  issue_valid;
    op_t   issue_type;
    val_t  issue_vj;
    val_t  issue_vk;
    logic  issue_qj_busy;
    logic  issue_qk_busy;
    tag_t  issue_qj;
    tag_t  issue_qk;
    tag_t  issue_entry;
    addr_t issue_pc;
    logic  rs_full;

    logic  alu_ready;
    tag_t  alu_entry;
    val_t  alu_val;
    logic  lsb_ready;
    tag_t  lsb_entry;
    val_t  lsb_val;

    // `type` is a reserved word, so the dispatched op is carried as exe_type.
    logic  execute;
    op_t   exe_type;
    val_t  val1;
    val_t  val2;
    tag_t  entry;
    addr_t nowPC;

    modport master (
        output issue_valid, issue_type, issue_vj, issue_vk, issue_qj_busy, issue_qk_busy,
               issue_qj, issue_qk, issue_entry, issue_pc,
               alu_ready, alu_entry, alu_val, lsb_ready, lsb_entry, lsb_val,
        input  rs_full, execute, exe_type, val1, val2, entry, nowPC
    );

    modport slave (
        input  issue_valid, issue_type, issue_vj, issue_vk, issue_qj_busy, issue_qk_busy,
               issue_qj, issue_qk, issue_entry, issue_pc,
               alu_ready, alu_entry, alu_val, lsb_ready, lsb_entry, lsb_val,
        output rs_full, execute, exe_type, val1, val2, entry, nowPC
    );

endinterface

// File: rtl/alu_rs_select.sv
// Lowest-index priority encoder: returns the first set bit of req and whether one exists.
module alu_rs_select #(
    parameter int N = 8
) (
    input  logic [N-1:0]         req,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);
    localparam int IDX_WIDTH = $clog2(N);

    // NOTE: every output gets a default before the loop, so no latch is inferred.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = IDX_WIDTH'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_rs.sv
// ALU reservation station: holds issued ops until both operands arrive, snoops the
// ALU/LSB result buses, and dispatches the lowest-index ready entry each cycle.
module alu_rs
    import alu_rs_pkg::*;
#(
    parameter int RS_SIZE = RS_SIZE_DEFAULT
) (
    input  logic    clk,
    input  logic    rst_in,
    input  logic    rdy_in,
    input  logic    clear_in,
    alu_rs_if.slave bus
);
    localparam int IDX_WIDTH = $clog2(RS_SIZE);

    rs_entry_t            slots [RS_SIZE];
    logic [RS_SIZE-1:0]   free_vec;
    logic [RS_SIZE-1:0]   ready_vec;
    logic [IDX_WIDTH-1:0] free_idx;
    logic [IDX_WIDTH-1:0] ready_idx;
    logic                 free_found;
    logic                 ready_found;
    bcast_t               alu_bc;
    bcast_t               lsb_bc;
    operand_t             issue_j;
    operand_t             issue_k;

    always_comb begin
        free_vec  = '0;
        ready_vec = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            free_vec[i]  = !slots[i].busy;
            ready_vec[i] = slots[i].busy && !slots[i].j.busy && !slots[i].k.busy;
        end
    end

    alu_rs_select #(.N(RS_SIZE)) u_free_sel (
        .req   (free_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    alu_rs_select #(.N(RS_SIZE)) u_ready_sel (
        .req   (ready_vec),
        .idx   (ready_idx),
        .found (ready_found)
    );

    // Built from pre-edge state, so a slot freed by this edge's dispatch is not offered.
    assign bus.rs_full = !free_found;

    assign alu_bc  = bcast_t'{ready: bus.alu_ready, tag: bus.alu_entry, val: bus.alu_val};
    assign lsb_bc  = bcast_t'{ready: bus.lsb_ready, tag: bus.lsb_entry, val: bus.lsb_val};
    assign issue_j = snoop(operand_t'{busy: bus.issue_qj_busy, tag: bus.issue_qj, val: bus.issue_vj},
                           alu_bc, lsb_bc);
    assign issue_k = snoop(operand_t'{busy: bus.issue_qk_busy, tag: bus.issue_qk, val: bus.issue_vk},
                           alu_bc, lsb_bc);

    // NOTE: sequential state uses non-blocking assignments only, so every read above sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_in) begin
            // NOTE: only the busy bits are reset; payload is don't-care while a slot is free.
            for (int i = 0; i < RS_SIZE; i++) begin
                slots[i].busy <= 1'b0;
            end
            bus.execute  <= 1'b0;
            bus.exe_type <= '0;
            bus.val1     <= '0;
            bus.val2     <= '0;
            bus.entry    <= '0;
            bus.nowPC    <= '0;
        end else if (rdy_in) begin
            if (clear_in) begin
                for (int i = 0; i < RS_SIZE; i++) begin
                    slots[i].busy <= 1'b0;
                end
                bus.execute <= 1'b0;
            end else begin
                // Snooping free or dispatching slots is harmless; their payload is dead.
                for (int i = 0; i < RS_SIZE; i++) begin
                    slots[i].j <= snoop(slots[i].j, alu_bc, lsb_bc);
                    slots[i].k <= snoop(slots[i].k, alu_bc, lsb_bc);
                end

                if (ready_found) begin
                    slots[ready_idx].busy <= 1'b0;
                    bus.execute  <= 1'b1;
                    bus.exe_type <= slots[ready_idx].op;
                    bus.val1     <= slots[ready_idx].j.val;
                    bus.val2     <= slots[ready_idx].k.val;
                    bus.entry    <= slots[ready_idx].dest;
                    bus.nowPC    <= slots[ready_idx].pc;
                end else begin
                    bus.execute  <= 1'b0;
                end

                // The free slot is never the ready slot, so this cannot collide with dispatch.
                if (bus.issue_valid && free_found) begin
                    slots[free_idx] <= rs_entry_t'{
                        busy: 1'b1,
                        op:   bus.issue_type,
                        j:    issue_j,
                        k:    issue_k,
                        dest: bus.issue_entry,
                        pc:   bus.issue_pc
                    };
                end
            end
        end
    end

endmodule

// File: doc/alu_rs.md
Name: alu_rs

Overview:
Reservation station that feeds the integer ALU.
- Buffers issued ALU-class instructions (B/I/R/auipc/lui/jal/jalr encodings in `type`) until both operands are available.
- Snoops the ALU and LSB result broadcasts to capture pending operands.
- Dispatches one ready instruction per cycle on the ALU's execute/type/val1/val2/entry/nowPC input interface.
- Sits between the decoder/issue stage and alu; alu results return to ROB and to this block.

Parameters:
RS_SIZE, 8, number of entries (power of two, ≥2)
OP_WIDTH, 7, op encoding width (`type[2:0]` class, `[5:3]` funct3, `[6]` variant)
VAL_WIDTH, 32, operand/result width
ROB_ID_WIDTH, 3, ROB index width; tags are ROB_ID_WIDTH+1 bits
ADDR_WIDTH, 32, PC width

Ports:
clk  in  1  clock
rst_in  in  1  synchronous, active-low reset (block resets on a rising clk edge while rst_in==0)
rdy_in  in  1  global enable; 0 freezes all state
clear_in  in  1  mispredict flush
issue_valid  in  1  new instruction this cycle
issue_type  in  OP_WIDTH  op encoding
issue_vj / issue_vk  in  VAL_WIDTH  operand values, valid when matching q*_busy==0
issue_qj_busy / issue_qk_busy  in  1  operand waits on a ROB tag
issue_qj / issue_qk  in  ROB_ID_WIDTH+1  producer tags
issue_entry  in  ROB_ID_WIDTH+1  destination ROB tag
issue_pc  in  ADDR_WIDTH  value passed as nowPC
rs_full  out  1  no free slot (combinational from entry valid bits)
alu_ready / alu_entry / alu_val  in  1 / ROB_ID_WIDTH+1 / VAL_WIDTH  ALU broadcast
lsb_ready / lsb_entry / lsb_val  in  1 / ROB_ID_WIDTH+1 / VAL_WIDTH  LSB broadcast
execute  out  1  dispatch strobe to alu
type  out  OP_WIDTH  dispatched op
val1 / val2  out  VAL_WIDTH  dispatched operands
entry  out  ROB_ID_WIDTH+1  dispatched ROB tag
nowPC  out  ADDR_WIDTH  dispatched PC

Behaviour:
- Reset (rst_in==0 at posedge): all entry valid bits 0. execute, type, val1, val2, entry and nowPC are all 0. rs_full is 0.
- rdy_in==0 (and rst_in==1): no state change; outputs hold; broadcasts during that cycle are lost by design (upstream also stalls).
- Priority per edge: reset > clear_in > normal operation.
- clear_in==1: invalidate all entries; execute<=0; ignore issue and broadcasts that cycle.
- Entry record: busy, op, vj, vk, qj_busy, qj, qk_busy, qk, dest, pc.
- Issue:
  - When issue_valid && !rs_full, write into the lowest-index free slot.
  - Issue while rs_full is a protocol error: ignored, flagged by bench assertion.
  - Issue-time forwarding: if issue_qj_busy and a broadcast this cycle matches issue_qj, store its value with qj_busy=0. Same rule for k.
  - If both ALU and LSB match the same tag, the ALU value wins (cannot legally differ).
- Wakeup: every cycle, each busy entry with qX_busy and qX==alu_entry (alu_ready) or ==lsb_entry (lsb_ready) captures the value and clears qX_busy.
- Select:
  - Ready = busy && !qj_busy && !qk_busy, evaluated on the registered state at the start of the cycle.
  - The lowest-index ready entry is dispatched: registered outputs load its fields, execute<=1, slot freed at the same edge.
  - No ready entry: execute<=0; the other outputs hold their last values.
- Latency: an operand woken by a broadcast at edge N is dispatchable at edge N+1, so execute is high in cycle N+1→N+2. Issue at edge N with all operands ready gives earliest dispatch at edge N+1.
- Simultaneous events:
  - A slot freed by dispatch at an edge is not reusable by an issue at that same edge (rs_full uses pre-edge state).
  - A dispatch and an issue to different slots in the same cycle are both legal.
- Throughput: 1 dispatch/cycle; the ALU has fixed 1-cycle latency, so there is no backpressure.
- Tag width is ROB_ID_WIDTH+1; compare all bits.

Decomposition:
- Shared package/`util.v`: OP_WIDTH, VAL_WIDTH, ROB_ID_WIDTH, ADDR_WIDTH defines, `OP_*_TYPE` class codes, RS_SIZE default.
- One natural sub-module: alu_rs_select, a priority encoder that takes a RS_SIZE-bit request vector and returns an index plus found, used both for the free-slot search and for ready-entry selection.

Test Plan:
1. Reset hold: drive rst_in=0 for 2 cycles with issue_valid=1 → execute=0, rs_full=0, and no dispatch after release.
2. Ready issue: issue addi (type class I, funct3 000), vj=5, vk=7, both busy=0, entry=3, pc=0x100 → one cycle later execute=1, val1=5, val2=7, entry=3, nowPC=0x100.
3. Wakeup:
   - Issue add with qj_busy=1, qj=2, vk=9 → no dispatch while waiting.
   - Then alu_ready=1, alu_entry=2, alu_val=0x11 → execute=1 next cycle with val1=0x11, val2=9.
4. Issue-time forwarding: issue with qk_busy=1, qk=6 while lsb_ready=1, lsb_entry=6, lsb_val=0xAB in the same cycle → dispatch next cycle with val2=0xAB.
5. Full/flush:
   - Issue 8 entries all waiting on tag 1 → rs_full=1, and a 9th issue is ignored.
   - Assert clear_in → rs_full=0 next cycle, and a later broadcast of tag 1 causes no execute.
6. Ordering and rdy_in:
   - Slots 0 and 2 become ready together → slot 0 dispatches first, slot 2 the next cycle.
   - rdy_in=0 for 3 cycles mid-sequence → outputs frozen, and the sequence resumes unchanged.
